// File: rtl/fp_add_issue_queue.sv
// Streaming front end for the multi-cycle fpadd unit: queues tagged operand
// pairs, issues one at a time, waits out the adder latency and returns the sum.
module fp_add_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int LATENCY = 26,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     add_start,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic                     add_done,
  input  logic [31:0]              add_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam int EW = TAG_W + 64;
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);
  localparam logic [CW-1:0] TO_M1  = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t             state;
  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      wait_cnt;
  logic [TAG_W-1:0]   cur_tag;
  logic [EW-1:0]      head;
  logic               full, empty, push, pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  // The only pop points are leaving IDLE and completing a HOLD handshake.
  assign pop      = !empty && ((state == IDLE) || (state == HOLD && out_ready));
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_tag, in_a, in_b};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      cur_tag   <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
    end else begin
      add_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            add_a     <= head[63:32];
            add_b     <= head[31:0];
            cur_tag   <= head[EW-1:64];
            add_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          // done may be stale from the previous op until LATENCY-1 has elapsed
          if (wait_cnt >= LAT_M1 && add_done) begin
            out_sum   <= add_sum;
            out_tag   <= cur_tag;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (wait_cnt == TO_M1) begin
            out_sum   <= add_sum;
            out_tag   <= cur_tag;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (pop) begin
              add_a     <= head[63:32];
              add_b     <= head[31:0];
              cur_tag   <= head[EW-1:64];
              add_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_issue_queue.sv
// Directed bench for fp_add_issue_queue with a small behavioural adder model.
module tb_fp_add_issue_queue;
  localparam int DEPTH = 4, TAG_W = 4, LATENCY = 26, TIMEOUT = 64;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic add_start, add_done;
  logic [31:0] add_a, add_b, add_sum;
  logic out_valid, out_ready = 1'b0, out_err, busy;
  logic [31:0] out_sum;
  logic [TAG_W-1:0] out_tag;
  logic [$clog2(DEPTH):0] count;

  fp_add_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .LATENCY(LATENCY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .add_start(add_start),
    .add_a(add_a), .add_b(add_b), .add_done(add_done), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_tag(out_tag), .out_err(out_err), .busy(busy), .count(count));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder model: mode 0 raises done 5 cycles after start (and leaves it high),
  // mode 1 holds done high permanently, mode 2 never raises done.
  int mode = 0;
  logic [31:0] m_sum;
  int m_cnt;
  logic m_done;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sum <= '0; m_cnt <= 0; m_done <= 1'b0;
    end else if (add_start) begin
      m_sum <= add_a + add_b; m_cnt <= 5; m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end
  assign add_done = (mode == 1) || (mode == 0 && m_done);
  assign add_sum  = m_sum;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    while (!in_ready && n < LIMIT) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_start(output int t);
    int n = 0;
    while (!add_start && n < LIMIT) begin @(negedge clk); n++; end
    check_eq("start_seen", add_start, 1);
    t = cyc;
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!out_valid && n < LIMIT) begin @(negedge clk); n++; end
    check_eq("valid_seen", out_valid, 1);
    t = cyc;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] va(input int i); return 32'h4000_0000 + i; endfunction
  function automatic logic [31:0] vb(input int i); return 32'h3F80_0000 + (i << 4); endfunction

  initial begin
    int t0, t1, tprev, n, bad, starts;
    logic [31:0] a0, b0, s;
    logic [TAG_W-1:0] tg;

    // reset state
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_count", count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_add_start", add_start, 0);
    check_eq("rst_out_sum", out_sum, 0);
    check_eq("rst_add_a", add_a, 0);
    reset = 1'b1;

    // single op: 1.0 + 2.0, tag 3; valid lands LATENCY+1 edges after start
    @(negedge clk);
    push(32'h3F80_0000, 32'h4000_0000, 3);
    wait_start(t0);
    check_eq("t1_add_a", add_a, 32'h3F80_0000);
    @(negedge clk);
    check_eq("t1_start_pulse", add_start, 0);
    wait_valid(t1);
    check_eq("t1_latency", t1 - t0, LATENCY + 1);
    check_eq("t1_tag", out_tag, 3);
    check_eq("t1_err", out_err, 0);
    check_eq("t1_sum", out_sum, 32'h7F80_0000);
    accept();

    // five back-to-back pushes with the consumer stalled
    for (int i = 0; i < 5; i++) push(va(i), vb(i), TAG_W'(i));
    check_eq("t2_count_full", count, 4);
    check_eq("t2_in_ready", in_ready, 0);
    in_valid = 1'b1; in_tag = 9;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    check_eq("t2_full_ignored", count, 4);
    out_ready = 1'b1;
    tprev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_valid(t1);
      check_eq("t2_tag", out_tag, k);
      check_eq("t2_sum", out_sum, va(k) + vb(k));
      if (k > 0) check_eq("t2_spacing", t1 - tprev, LATENCY + 2);
      tprev = t1;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("t2_idle_busy", busy, 0);
    check_eq("t2_idle_count", count, 0);

    // done held high: no early capture, operands stable through WAIT
    mode = 1;
    push(32'h1234_5678, 32'h0000_1111, 7);
    wait_start(t0);
    a0 = add_a; b0 = add_b; bad = 0; n = 0;
    while (!out_valid && n < LIMIT) begin
      @(negedge clk); n++;
      if (add_a != a0 || add_b != b0) bad++;
    end
    check_eq("t3_valid_seen", out_valid, 1);
    check_eq("t3_latency", cyc - t0, LATENCY + 1);
    check_eq("t3_operands_stable", bad, 0);
    check_eq("t3_tag", out_tag, 7);
    check_eq("t3_sum", out_sum, 32'h1234_6789);
    accept();

    // done never rises: timeout capture, then the next pair runs normally
    mode = 2;
    push(va(10), vb(10), 10);
    push(va(11), vb(11), 11);
    wait_start(t0);
    wait_valid(t1);
    check_eq("t4_timeout_latency", t1 - t0, TIMEOUT + 1);
    check_eq("t4_err", out_err, 1);
    check_eq("t4_tag", out_tag, 10);
    check_eq("t4_sum", out_sum, va(10) + vb(10));
    mode = 0;
    accept();
    wait_start(t0);
    wait_valid(t1);
    check_eq("t4_next_latency", t1 - t0, LATENCY + 1);
    check_eq("t4_next_err", out_err, 0);
    check_eq("t4_next_tag", out_tag, 11);
    accept();

    // stall in HOLD for 10 cycles
    push(va(12), vb(12), 12);
    push(va(13), vb(13), 13);
    wait_valid(t1);
    s = out_sum; tg = out_tag; bad = 0; starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_sum != s || out_tag != tg || !out_valid) bad++;
      if (add_start) starts++;
    end
    check_eq("t5_hold_stable", bad, 0);
    check_eq("t5_no_start", starts, 0);
    check_eq("t5_tag", tg, 12);
    check_eq("t5_sum", s, va(12) + vb(12));
    accept();
    check_eq("t5_next_start", add_start, 1);
    wait_valid(t1);
    check_eq("t5_next_tag", out_tag, 13);
    accept();

    // reset during WAIT with two pairs queued
    for (int i = 1; i <= 3; i++) push(va(i), vb(i), TAG_W'(i));
    repeat (5) @(negedge clk);
    check_eq("t6_pre_count", count, 2);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_valid", out_valid, 0);
    check_eq("t6_rst_count", count, 0);
    check_eq("t6_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid || add_start) bad++;
    end
    check_eq("t6_no_stale", bad, 0);
    check_eq("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
